// File: rtl/mc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Instruction- and data-memory handshake bundle between the multicycle
// control unit and the memories.
//   imem_req  : fetch request          (controller -> imem)
//   imem_ack  : instruction valid      (imem -> controller)
//   instr     : 16-bit instruction     (imem -> controller)
//   dmem_req  : data access request    (controller -> dmem)
//   dmem_we   : data access is a store (controller -> dmem)
//   dmem_ack  : data access done       (dmem -> controller)
// master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface mc_ctrl_fsm_if;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] instr;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, instr, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, instr, dmem_ack
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle control unit for the 8-bit CPU. Fetches a 16-bit instruction,
// then steps it through DECODE/EXECUTE/MEMORY/WRITEBACK while driving the
// register file, ALU op, data-memory request and PC update.
//
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   bus             : imem/dmem handshake (mc_ctrl_fsm_if.master)
//   zero            : R[rf_read_addr1] == 0, from datapath
//   rf_writ_en      : register file write enable
//   rf_mem_en       : register file read enable
//   rf_read_addr1/2 : operand A/B addresses
//   rf_writ_addr    : destination address
//   wb_sel          : writeback mux (0 ALU, 1 immediate, 2 memory)
//   imm             : IR[7:0]
//   alu_op          : ADD 0, SUB 1, AND 2, OR 3, XOR 4
//   pc_inc, pc_load : PC <= PC+1 / PC <= imm pulses
//   halted          : core stopped
//   bus_err         : sticky memory-timeout flag
//   illegal_op      : sticky illegal-opcode flag (ILLEGAL_TRAP_EN only)
//
// Build option: define ILLEGAL_TRAP_EN to trap opcodes A..E into HALT and
// expose illegal_op; otherwise those opcodes behave as NOP.
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15   // 1..255
) (
    input  logic              clk,
    input  logic              rst,
    mc_ctrl_fsm_if.master     bus,
    input  logic              zero,
    output logic              rf_writ_en,
    output logic              rf_mem_en,
    output logic [3:0]        rf_read_addr1,
    output logic [3:0]        rf_read_addr2,
    output logic [3:0]        rf_writ_addr,
    output logic [1:0]        wb_sel,
    output logic [7:0]        imm,
    output logic [2:0]        alu_op,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              halted,
    output logic              bus_err
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic              illegal_op
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  wait_q, wait_d;
    logic        bus_err_q, bus_err_d;
`ifdef ILLEGAL_TRAP_EN
    logic        ill_q, ill_d;
`endif

    // instruction fields
    logic [3:0] op, rd, rs1, rs2;
    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:8];
    assign rs1 = ir_q[7:4];
    assign rs2 = ir_q[3:0];

    logic is_nop, is_alu, is_ldi, is_ld, is_st, is_beqz, is_hlt, is_ill;
    assign is_nop  = (op == 4'h0);
    assign is_alu  = (op >= 4'h1) && (op <= 4'h5);
    assign is_ldi  = (op == 4'h6);
    assign is_ld   = (op == 4'h7);
    assign is_st   = (op == 4'h8);
    assign is_beqz = (op == 4'h9);
    assign is_hlt  = (op == 4'hF);
    assign is_ill  = (op >= 4'hA) && (op <= 4'hE);

    // illegal opcodes fall through as NOP unless trapping is built in
    logic ill_as_nop;
`ifdef ILLEGAL_TRAP_EN
    assign ill_as_nop = 1'b0;
`else
    assign ill_as_nop = is_ill;
`endif

    // last waiting cycle: an ack here still wins, otherwise we time out
    logic wait_hit;
    assign wait_hit = (wait_q == 8'(MEM_TIMEOUT - 1));

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            ill_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
            ill_q     <= ill_d;
`endif
        end
    end

    // ---- next-state logic ----
    // wait counter is zero everywhere except while waiting in FETCH/MEMORY,
    // so it is already clear on entry to either state.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wait_d    = '0;
        bus_err_d = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
        ill_d     = ill_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end else if (wait_hit) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (is_alu || is_ldi)     state_d = S_WRITEBACK;
                else if (is_ld || is_st)  state_d = S_MEMORY;
                else if (is_hlt)          state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                else if (is_ill) begin
                    state_d = S_HALT;
                    ill_d   = 1'b1;
                end
`endif
                else                      state_d = S_FETCH;
            end
            S_MEMORY: begin
                if (bus.dmem_ack) begin
                    state_d = is_ld ? S_WRITEBACK : S_FETCH;
                end else if (wait_hit) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    // ---- output logic ----
    // Everything is forced low while rst is held, independent of state.
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        rf_writ_en    = 1'b0;
        rf_mem_en     = 1'b0;
        rf_read_addr1 = '0;
        rf_read_addr2 = '0;
        rf_writ_addr  = '0;
        wb_sel        = 2'd0;
        imm           = '0;
        alu_op        = '0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        halted        = 1'b0;
        bus_err       = 1'b0;
        if (!rst) begin
            imm     = ir_q[7:0];
            wb_sel  = is_ldi ? 2'd1 : (is_ld ? 2'd2 : 2'd0);
            bus_err = bus_err_q;
            if (state_q == S_DECODE || state_q == S_EXECUTE || state_q == S_MEMORY) begin
                rf_mem_en     = 1'b1;
                // BEQZ tests R[rd], so rd goes out on port A
                rf_read_addr1 = is_beqz ? rd : rs1;
                rf_read_addr2 = rs2;
            end
            if (is_alu && (state_q == S_DECODE || state_q == S_EXECUTE ||
                           state_q == S_WRITEBACK))
                alu_op = 3'(op - 4'd1);
            case (state_q)
                S_FETCH: bus.imem_req = 1'b1;
                S_EXECUTE: begin
                    if (is_beqz) begin
                        pc_load = zero;
                        pc_inc  = !zero;
                    end else if (is_nop || ill_as_nop) begin
                        pc_inc = 1'b1;
                    end
                end
                S_MEMORY: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = is_st;
                    // store retires on its ack cycle
                    pc_inc       = is_st && bus.dmem_ack;
                end
                S_WRITEBACK: begin
                    rf_writ_en   = 1'b1;
                    rf_writ_addr = rd;
                    pc_inc       = 1'b1;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = !rst && ill_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if bus();
    logic       zero = 1'b0;
    logic       rf_writ_en, rf_mem_en, pc_inc, pc_load, halted, bus_err;
    logic [3:0] rf_read_addr1, rf_read_addr2, rf_writ_addr;
    logic [1:0] wb_sel;
    logic [7:0] imm;
    logic [2:0] alu_op;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    mc_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .bus(bus), .zero(zero),
        .rf_writ_en(rf_writ_en), .rf_mem_en(rf_mem_en),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_writ_addr(rf_writ_addr), .wb_sel(wb_sel), .imm(imm),
        .alu_op(alu_op), .pc_inc(pc_inc), .pc_load(pc_load),
        .halted(halted), .bus_err(bus_err)
`ifdef ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    // one instruction: stimulus + expected observation (aop < 0 = don't care)
    typedef struct {
        logic [15:0] instr;
        bit          zero;
        int          dlat;
        int          lat, wr, waddr, wsel, pinc, pload, ra1, ra2, aop, dreq, dwe;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---- monitor / scoreboard: collect one instruction, compare on return to FETCH or HALT ----
    bit open = 0;
    int cyc, m_wr, m_wa, m_ws, m_pi, m_pl, m_ra1, m_ra2, m_aop, m_dreq, m_dwe, m_imm;

    always @(negedge clk) begin
        if (rst) begin
            open = 0;
            exp_q.delete();
        end else begin
            if (open) begin
                if (bus.imem_req || halted) begin
                    vec_t e;
                    open = 0;
                    if (exp_q.size() == 0) chk("sb_empty", 0, 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("latency", cyc, e.lat);
                        chk("wr_cnt", m_wr, e.wr);
                        chk("wr_addr", m_wa, e.waddr);
                        chk("wb_sel", m_ws, e.wsel);
                        chk("pc_inc_cnt", m_pi, e.pinc);
                        chk("pc_load_cnt", m_pl, e.pload);
                        chk("rd_addr1", m_ra1, e.ra1);
                        chk("rd_addr2", m_ra2, e.ra2);
                        if (e.aop >= 0) chk("alu_op", m_aop, e.aop);
                        chk("dmem_req_cyc", m_dreq, e.dreq);
                        chk("dmem_we", m_dwe, e.dwe);
                        chk("imm", m_imm, int'(e.instr[7:0]));
                    end
                end else begin
                    cyc++;
                    if (cyc == 2) begin m_ra1 = rf_read_addr1; m_ra2 = rf_read_addr2; end
                    if (cyc == 3) begin m_aop = alu_op; m_imm = imm; end
                    if (rf_writ_en) begin m_wr++; m_wa = rf_writ_addr; m_ws = wb_sel; end
                    if (pc_inc)  m_pi++;
                    if (pc_load) begin
                        m_pl++;
                        chk("pc_load_excl", int'(pc_inc | rf_writ_en), 0);
                    end
                    if (bus.dmem_req) begin m_dreq++; m_dwe = m_dwe | int'(bus.dmem_we); end
                end
            end
            if (!open && bus.imem_req && bus.imem_ack) begin
                open = 1; cyc = 1;
                m_wr = 0; m_wa = 0; m_ws = 0; m_pi = 0; m_pl = 0;
                m_ra1 = 0; m_ra2 = 0; m_aop = 0; m_dreq = 0; m_dwe = 0; m_imm = 0;
            end
        end
    end

    // ---- driver: fetch one instruction, serve dmem after dlat wait cycles ----
    // Spurious acks and garbage instr words are driven outside the handshake.
    task automatic do_instr(input vec_t v);
        int t = 0;
        int dcnt = 0;
        while (!bus.imem_req && t < 20) begin @(posedge clk); #1; t++; end
        if (!bus.imem_req) begin chk("fetch_wait_timeout", 0, 1); return; end
        exp_q.push_back(v);
        bus.instr = v.instr; bus.imem_ack = 1'b1; zero = v.zero;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        for (t = 0; t < 60; t++) begin
            if (bus.imem_req || halted) break;
            bus.instr    = 16'($urandom);
            bus.imem_ack = 1'($urandom_range(0, 1));
            if (bus.dmem_req) begin
                bus.dmem_ack = (dcnt == v.dlat);
                dcnt++;
            end else bus.dmem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        if (!(bus.imem_req || halted)) chk("instr_done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        int cnt;
        bus.imem_ack = 1'b0; bus.instr = '0; bus.dmem_ack = 1'b0;

        //                 instr    z dl lat wr wa ws pi pl ra1 ra2 aop dreq dwe
        tbl.push_back('{16'h635A, 0, 0, 4, 1, 3, 1, 1, 0, 5, 10, -1, 0, 0});
        tbl.push_back('{16'h1123, 0, 0, 4, 1, 1, 0, 1, 0, 2, 3, 0, 0, 0});
        tbl.push_back('{16'h2456, 0, 0, 4, 1, 4, 0, 1, 0, 5, 6, 1, 0, 0});
        tbl.push_back('{16'h3789, 0, 0, 4, 1, 7, 0, 1, 0, 8, 9, 2, 0, 0});
        tbl.push_back('{16'h4ABC, 0, 0, 4, 1, 10, 0, 1, 0, 11, 12, 3, 0, 0});
        tbl.push_back('{16'h5DEF, 0, 0, 4, 1, 13, 0, 1, 0, 14, 15, 4, 0, 0});
        tbl.push_back('{16'h7040, 0, 3, 8, 1, 0, 2, 1, 0, 4, 0, -1, 4, 0});
        tbl.push_back('{16'h7931, 0, 0, 5, 1, 9, 2, 1, 0, 3, 1, -1, 1, 0});
        tbl.push_back('{16'h8262, 0, 0, 4, 0, 0, 0, 1, 0, 6, 2, -1, 1, 1});
        tbl.push_back('{16'h8113, 0, 2, 6, 0, 0, 0, 1, 0, 1, 3, -1, 3, 1});
        tbl.push_back('{16'h9520, 1, 0, 3, 0, 0, 0, 0, 1, 5, 0, -1, 0, 0});
        tbl.push_back('{16'h9520, 0, 0, 3, 0, 0, 0, 1, 0, 5, 0, -1, 0, 0});
        tbl.push_back('{16'h9A77, 1, 0, 3, 0, 0, 0, 0, 1, 10, 7, -1, 0, 0});
        tbl.push_back('{16'h0000, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, -1, 0, 0});

        // reset: all outputs low while rst is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs_a", int'({bus.imem_req, bus.dmem_req, bus.dmem_we, rf_writ_en,
                                rf_mem_en, pc_inc, pc_load, halted, bus_err, alu_op, wb_sel}), 0);
        chk("rst_outs_b", int'({rf_read_addr1, rf_read_addr2, rf_writ_addr, imm}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("imem_req_after_rst", int'(bus.imem_req), 1);
        @(posedge clk); #1;

        foreach (tbl[i]) do_instr(tbl[i]);

        // ack in the 15th waiting cycle still wins over the timeout
        do_reset();
        repeat (14) begin @(posedge clk); #1; end
        do_instr('{16'h0000, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, -1, 0, 0});
        @(negedge clk);
        chk("ack_wins_bus_err", int'(bus_err), 0);

        // fetch timeout: 15 waiting cycles then HALT with bus_err
        do_reset();
        cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (halted) break;
            if (bus.imem_req) cnt++;
        end
        chk("fetch_to_cycles", cnt, 15);
        chk("fetch_to_halted", int'(halted), 1);
        chk("fetch_to_bus_err", int'(bus_err), 1);
        chk("fetch_to_imem_req", int'(bus.imem_req), 0);
        bus.imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("halt_sticky", int'(halted), 1);
        bus.imem_ack = 1'b0;
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("rst_clears_bus_err", int'(bus_err), 0);
        chk("rst_clears_halt", int'(halted), 0);
        chk("rst_fetch", int'(bus.imem_req), 1);

        // data-memory timeout: LD never acked
        @(posedge clk); #1;
        do_instr('{16'h7040, 0, 1000, 18, 0, 0, 0, 0, 0, 4, 0, -1, 15, 0});
        @(negedge clk);
        chk("dmem_to_halted", int'(halted), 1);
        chk("dmem_to_bus_err", int'(bus_err), 1);

        // HLT
        do_reset();
        do_instr('{16'hF000, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0});
        @(negedge clk);
        chk("hlt_halted", int'(halted), 1);
        chk("hlt_bus_err", int'(bus_err), 0);

        // reset in the middle of MEMORY: request drops, no writeback
        do_reset();
        bus.instr = 16'h7040; bus.imem_ack = 1'b1;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        cnt = 0;
        while (!bus.dmem_req && cnt < 10) begin @(posedge clk); #1; cnt++; end
        chk("mid_mem_reached", int'(bus.dmem_req), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_mem_dreq_in_rst", int'(bus.dmem_req), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            cnt += int'(rf_writ_en) + int'(bus.dmem_req) + int'(!bus.imem_req);
        end
        chk("mid_mem_after_rst", cnt, 0);

        // illegal opcode
        @(posedge clk); #1;
`ifdef ILLEGAL_TRAP_EN
        do_instr('{16'hA000, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0});
        @(negedge clk);
        chk("ill_halted", int'(halted), 1);
        chk("ill_flag", int'(illegal_op), 1);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("ill_flag_rst", int'(illegal_op), 0);
`else
        do_instr('{16'hA000, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, -1, 0, 0});
        @(negedge clk);
        chk("ill_no_halt", int'(halted), 0);
`endif

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
